// File: rtl/noc_packet_source.sv
// Flit-level packet generator for a valid/ready NoC link: one start command emits
// a header flit, optional payload flits and a final flit. Flow control is per flit.
module noc_packet_source #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int DEST_WIDTH      = 5,
    parameter int MAX_LEN         = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [3:0]                   pkt_len,
    input  logic [DEST_WIDTH-1:0]        dest,
    output logic [FLIT_DATA_WIDTH+1:0]   flit,
    output logic                         valid,
    input  logic                         ready,
    output logic                         busy,
    output logic [7:0]                   pkt_count
);
    localparam int FLIT_TYPE_WIDTH = 2;
    localparam int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;

    localparam logic [1:0] T_PAYLOAD = 2'b00;
    localparam logic [1:0] T_HEADER  = 2'b01;
    localparam logic [1:0] T_LAST    = 2'b10;
    localparam logic [1:0] T_SINGLE  = 2'b11;
    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state, state_n;
    logic [3:0]               idx, idx_n;
    logic [3:0]               len_q, len_n;
    logic [DEST_WIDTH-1:0]    dest_q, dest_n;
    logic [7:0]               count_n;
    logic [FLIT_WIDTH-1:0]    flit_n;
    logic [FLIT_DATA_WIDTH-1:0] data_n;
    logic [1:0]               type_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len_q;
        dest_n  = dest_q;
        count_n = pkt_count;
        case (state)
            IDLE: begin
                if (start && pkt_len != 4'd0 && pkt_len <= MAX_LEN_L) begin
                    state_n = SEND;
                    idx_n   = 4'd0;
                    len_n   = pkt_len;
                    dest_n  = dest;
                end
            end
            SEND: begin
                // valid is high throughout SEND, so ready alone marks a transfer
                if (ready) begin
                    if (idx == len_q - 4'd1) begin
                        state_n = IDLE;
                        idx_n   = 4'd0;
                        count_n = pkt_count + 8'd1;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Flit is built from next-state values so the output register holds it
    // stable under backpressure and presents it on the same edge as valid.
    always_comb begin
        data_n = '0;
        type_n = T_PAYLOAD;
        if (idx_n == 4'd0) begin
            type_n = (len_n == 4'd1) ? T_SINGLE : T_HEADER;
            data_n[FLIT_DATA_WIDTH-1 -: DEST_WIDTH] = dest_n;
            data_n[7:0] = count_n;
        end else begin
            type_n = (idx_n == len_n - 4'd1) ? T_LAST : T_PAYLOAD;
            data_n[15:8] = count_n;
            data_n[7:0]  = {4'd0, idx_n};
        end
        flit_n = (state_n == SEND) ? {type_n, data_n} : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            len_q     <= '0;
            dest_q    <= '0;
            pkt_count <= '0;
            flit      <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            len_q     <= len_n;
            dest_q    <= dest_n;
            pkt_count <= count_n;
            flit      <= flit_n;
        end
    end

    assign valid = (state == SEND);
    assign busy  = (state == SEND);

endmodule

// File: tb/tb_noc_packet_source.sv
// Directed bench for noc_packet_source: inputs driven and outputs sampled on the
// falling edge, expected flits built from hand-chosen dest/seq/idx values.
module tb_noc_packet_source;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [3:0]  pkt_len = '0;
    logic [4:0]  dest = '0;
    logic [33:0] flit;
    logic        valid, busy;
    logic [7:0]  pkt_count;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_packet_source dut (
        .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .dest(dest),
        .flit(flit), .valid(valid), .ready(ready), .busy(busy), .pkt_count(pkt_count)
    );

    function automatic logic [33:0] hdr(input logic single, input logic [4:0] d, input logic [7:0] s);
        return {(single ? 2'b11 : 2'b01), d, 19'b0, s};
    endfunction

    function automatic logic [33:0] pay(input logic last, input logic [7:0] s, input logic [3:0] i);
        return {(last ? 2'b10 : 2'b00), 16'b0, s, 4'b0, i};
    endfunction

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; pkt_len = 4'd2; dest = 5'd1;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (flit !== 34'h0) begin errors++; $display("FAIL reset_flit got %h exp 0", flit); end
        checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", pkt_count); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %b exp 0", valid); end
        start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        dest = 5'd5; pkt_len = 4'd1; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", valid); end
        checks++; if (flit !== hdr(1'b1, 5'd5, 8'd0)) begin errors++; $display("FAIL single_flit got %h exp %h", flit, hdr(1'b1, 5'd5, 8'd0)); end
        checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL single_count_pre got %0d exp 0", pkt_count); end
        @(negedge clk);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got v%b b%b exp 0 0", valid, busy); end
        checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", pkt_count); end
    endtask

    task automatic test_four();
        logic [33:0] exp_f [4];
        exp_f[0] = hdr(1'b0, 5'd3, 8'd1);
        exp_f[1] = pay(1'b0, 8'd1, 4'd1);
        exp_f[2] = pay(1'b0, 8'd1, 4'd2);
        exp_f[3] = pay(1'b1, 8'd1, 4'd3);
        dest = 5'd3; pkt_len = 4'd4; start = 1'b1; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); start = 1'b0;
            checks++; if (valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL four_vb[%0d] got v%b b%b exp 1 1", i, valid, busy); end
            checks++; if (flit !== exp_f[i]) begin errors++; $display("FAIL four_flit[%0d] got %h exp %h", i, flit, exp_f[i]); end
        end
        @(negedge clk);
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL four_done got v%b b%b exp 0 0", valid, busy); end
        checks++; if (pkt_count !== 8'd2) begin errors++; $display("FAIL four_count got %0d exp 2", pkt_count); end
    endtask

    task automatic test_backpressure();
        logic rp [6];
        logic [33:0] prev, exp_v;
        int exp_idx;
        rp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        prev = '0;
        exp_idx = 0;
        dest = 5'd10; pkt_len = 4'd3; start = 1'b1; ready = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ready = rp[k];
            exp_v = (exp_idx == 0) ? hdr(1'b0, 5'd10, 8'd2) : pay(exp_idx == 2, 8'd2, 4'(exp_idx));
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", k, valid); end
            checks++; if (flit !== exp_v) begin errors++; $display("FAIL bp_flit[%0d] got %h exp %h", k, flit, exp_v); end
            if (k > 0 && !rp[k-1]) begin
                checks++; if (flit !== prev) begin errors++; $display("FAIL bp_hold[%0d] got %h exp %h", k, flit, prev); end
            end
            prev = flit;
            @(negedge clk);
            if (rp[k]) exp_idx++;
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_done got %b exp 0", valid); end
        checks++; if (pkt_count !== 8'd3) begin errors++; $display("FAIL bp_count got %0d exp 3", pkt_count); end
        ready = 1'b1;
    endtask

    task automatic test_illegal();
        dest = 5'd4; pkt_len = 4'd0; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL illegal_vb[%0d] got v%b b%b exp 0 0", i, valid, busy); end
            checks++; if (pkt_count !== 8'd3) begin errors++; $display("FAIL illegal_count[%0d] got %0d exp 3", i, pkt_count); end
            @(negedge clk);
        end
    endtask

    task automatic test_overlap();
        logic [33:0] exp_f [3];
        exp_f[0] = hdr(1'b0, 5'd9, 8'd3);
        exp_f[1] = pay(1'b0, 8'd3, 4'd1);
        exp_f[2] = pay(1'b1, 8'd3, 4'd2);
        dest = 5'd9; pkt_len = 4'd3; start = 1'b1; ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b1; pkt_len = 4'd2; dest = 5'd3; end
            else start = 1'b0;
            checks++; if (flit !== exp_f[i]) begin errors++; $display("FAIL overlap_flit[%0d] got %h exp %h", i, flit, exp_f[i]); end
        end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL overlap_done got %b exp 0", valid); end
        checks++; if (pkt_count !== 8'd4) begin errors++; $display("FAIL overlap_count got %0d exp 4", pkt_count); end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL overlap_no_queue got %b exp 0", valid); end
    endtask

    task automatic test_async_reset();
        dest = 5'd1; pkt_len = 4'd4; start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (flit !== pay(1'b0, 8'd4, 4'd2)) begin errors++; $display("FAIL areset_pre got %h exp %h", flit, pay(1'b0, 8'd4, 4'd2)); end
        #2 rst = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_vb got v%b b%b exp 0 0", valid, busy); end
        checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", pkt_count); end
        checks++; if (flit !== 34'h0) begin errors++; $display("FAIL areset_flit got %h exp 0", flit); end
        @(negedge clk); rst = 1'b1;
        dest = 5'd6; pkt_len = 4'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (flit !== hdr(1'b0, 5'd6, 8'd0)) begin errors++; $display("FAIL areset_hdr got %h exp %h", flit, hdr(1'b0, 5'd6, 8'd0)); end
        @(negedge clk);
        checks++; if (flit !== pay(1'b1, 8'd0, 4'd1)) begin errors++; $display("FAIL areset_last got %h exp %h", flit, pay(1'b1, 8'd0, 4'd1)); end
        @(negedge clk);
        checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL areset_count_after got %0d exp 1", pkt_count); end
    endtask

    task automatic test_wrap();
        logic [8:0] iv;
        rst = 1'b0; #1;
        @(negedge clk); rst = 1'b1; ready = 1'b1; pkt_len = 4'd1;
        for (int i = 0; i < 257; i++) begin
            iv = 9'(i);
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wrap_gap[%0d] got %b exp 0", i, valid); end
            dest = iv[4:0]; start = 1'b1;
            @(negedge clk); start = 1'b0;
            checks++; if (flit !== hdr(1'b1, iv[4:0], iv[7:0])) begin errors++; $display("FAIL wrap_flit[%0d] got %h exp %h", i, flit, hdr(1'b1, iv[4:0], iv[7:0])); end
            @(negedge clk);
            if (i == 255) begin
                checks++; if (pkt_count !== 8'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", pkt_count); end
            end
        end
        checks++; if (pkt_count !== 8'd1) begin errors++; $display("FAIL wrap_count_after got %0d exp 1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_four();
        test_backpressure();
        test_illegal();
        test_overlap();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
